fifo_rd_drain: RTL and testbench

Read-side consumer for the async FIFO, running entirely in the `rd_clk` domain. It pops words whenever the FIFO is non-empty and downstream space exists, absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, and presents the data as a valid/ready stream. It counts delivered words and records any FIFO underflow indication as a sticky error.

---
 rtl/fifo_rd_drain_if.sv | 52 +++++
 rtl/fifo_rd_drain.sv | 126 ++++++++++++
 tb/tb_fifo_rd_drain.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_drain_if.sv
// fifo_rd_drain_if
//   Bundles the two handshakes of the read-side drain block: the pop side
//   towards the async FIFO and the valid/ready stream towards the consumer.
//
//   Signals:
//     rd_en      FIFO pop request (driven by the drain block)
//     empty      FIFO empty flag, same-cycle
//     rdata      FIFO read data, valid the cycle after rd_en
//     underflow  FIFO underflow pulse
//     m_data     head-of-buffer word (driven by the drain block)
//     m_valid    m_data is valid (driven by the drain block)
//     m_ready    downstream accept
//
//   Modports:
//     master  the drain block itself
//     slave   the environment (FIFO plus downstream consumer)

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface fifo_rd_drain_if #(
    parameter int DATA_WIDTH = `DATA_WIDTH
);
    logic                  rd_en;
    logic                  empty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  underflow;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output rd_en,
        input  empty,
        input  rdata,
        input  underflow,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  rd_en,
        output empty,
        output rdata,
        output underflow,
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain
//   Read-side consumer for the async FIFO, entirely in the rd_clk domain.
//   Pops a word whenever the FIFO is non-empty and there is room for it,
//   absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer and
//   presents the words as a valid/ready stream. Counts delivered words and
//   keeps a sticky flag for any FIFO underflow indication.
//
//   Ports:
//     rd_clk_i    sole clock, rising edge
//     rst_i       synchronous reset, active low
//     en_i        drain enable; low stops new pops, buffer still drains
//     bus         fifo_rd_drain_if.master (FIFO pop side + output stream)
//     occ_o       buffer occupancy, 0..2
//     word_cnt_o  words accepted downstream, wraps modulo 2^CNT_WIDTH
//     err_uf_o    sticky underflow flag, cleared only by reset

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module fifo_rd_drain #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 rd_clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    fifo_rd_drain_if.master      bus,
    output logic [1:0]           occ_o,
    output logic [CNT_WIDTH-1:0] word_cnt_o,
    output logic                 err_uf_o
);

    // Skid buffer storage and pointers
    logic [DATA_WIDTH-1:0] mem0_q, mem0_d;
    logic [DATA_WIDTH-1:0] mem1_q, mem1_d;
    logic                  wptr_q, wptr_d;
    logic                  rptr_q, rptr_d;
    logic [1:0]            occ_q,  occ_d;

    // A pop issued last cycle whose data is on rdata this cycle
    logic                  inflight_q, inflight_d;

    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic                  err_uf_q,   err_uf_d;

    logic                  m_valid;
    logic                  accept;
    logic                  rd_en;
    logic [2:0]            occ_sum;

    assign m_valid = (occ_q != 2'd0);
    assign accept  = m_valid & bus.m_ready;

    // Occupancy once this cycle's capture and accept have taken effect.
    // An accept implies occ_q >= 1, so this never goes negative, and the
    // pop credit below keeps occ_q + inflight_q <= 2.
    assign occ_sum = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, accept};

    // A pop is allowed only if its word will still have a free slot when it
    // lands; counting the accept lets rd_en re-assert in the same cycle that
    // m_ready returns.
    assign rd_en = rst_i & en_i & ~bus.empty & (occ_sum < 3'd2);

    always_comb begin
        mem0_d      = mem0_q;
        mem1_d      = mem1_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        occ_d       = occ_sum[1:0];
        inflight_d  = rd_en;
        word_cnt_d  = word_cnt_q;
        err_uf_d    = err_uf_q | bus.underflow;

        if (inflight_q) begin
            if (wptr_q) begin
                mem1_d = bus.rdata;
            end else begin
                mem0_d = bus.rdata;
            end
            wptr_d = ~wptr_q;
        end

        if (accept) begin
            rptr_d     = ~rptr_q;
            word_cnt_d = word_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Reset discards buffered words and any word still in flight; the
    // in-flight word has already left the FIFO and is deliberately lost.
    always_ff @(posedge rd_clk_i) begin
        if (!rst_i) begin
            mem0_q     <= '0;
            mem1_q     <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            word_cnt_q <= '0;
            err_uf_q   <= 1'b0;
        end else begin
            mem0_q     <= mem0_d;
            mem1_q     <= mem1_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            word_cnt_q <= word_cnt_d;
            err_uf_q   <= err_uf_d;
        end
    end

    assign bus.rd_en   = rd_en;
    assign bus.m_valid = m_valid;
    assign bus.m_data  = rptr_q ? mem1_q : mem0_q;

    assign occ_o      = occ_q;
    assign word_cnt_o = word_cnt_q;
    assign err_uf_o   = err_uf_q;

    // The credit check must keep the buffer from ever holding three words.
    a_occ_bound : assert property (@(posedge rd_clk_i) disable iff (!rst_i)
        (occ_q != 2'd3) && ({1'b0, occ_q} + {2'b00, inflight_q} <= 3'd2));

endmodule

// File: tb/tb_fifo_rd_drain.sv
module tb_fifo_rd_drain;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    occ;
    logic [CW-1:0] word_cnt;
    logic          err_uf;

    always #5 clk = ~clk;

    fifo_rd_drain_if #(.DATA_WIDTH(DW)) ifc ();

    fifo_rd_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .rd_clk_i   (clk),
        .rst_i      (rst),
        .en_i       (en),
        .bus        (ifc),
        .occ_o      (occ),
        .word_cnt_o (word_cnt),
        .err_uf_o   (err_uf)
    );

    typedef struct {
        logic        en;
        logic        rdy;
        int          n_push;
        int          n_cyc;
        int          exp_pulses;
        logic [1:0]  exp_occ;
        logic        exp_valid;
        logic [7:0]  exp_head;
        int          exp_cnt;
    } vec_t;

    vec_t vecs [8];

    int          n_vec;
    int          n_bad;
    int          rd_pulses;
    int          cyc_n;
    int          first_rd;
    int          first_val;
    logic        s_rd_en;
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] got [$];
    logic [DW-1:0] next_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        ifc.empty = 1'b0;
    endtask

    // Called at a negedge. Samples outputs shortly after, then plays the
    // FIFO's part just after the following posedge and returns at the
    // next negedge.
    task automatic cyc();
        #1;
        s_rd_en = ifc.rd_en;
        if (s_rd_en) begin
            rd_pulses++;
            if (first_rd < 0) first_rd = cyc_n;
        end
        if (ifc.m_valid && first_val < 0) first_val = cyc_n;
        if (ifc.m_valid && ifc.m_ready) got.push_back(ifc.m_data);
        @(posedge clk);
        #1;
        if (s_rd_en) begin
            if (fifo_q.size() == 0) begin
                check("pop_on_empty", 32'd1, 32'd0);
            end else begin
                ifc.rdata = fifo_q.pop_front();
            end
        end
        ifc.empty = (fifo_q.size() == 0);
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic fresh();
        rst = 1'b0;
        en = 1'b0;
        ifc.m_ready = 1'b0;
        ifc.underflow = 1'b0;
        ifc.rdata = '0;
        fifo_q.delete();
        ifc.empty = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;
        got.delete();
        rd_pulses = 0;
        cyc_n = 0;
        first_rd = -1;
        first_val = -1;
    endtask

    task automatic check_seq(input string name, input int base, input int step, input int n);
        check({name, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_word%0d", name, i),
                  (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF,
                  (base + i * step) & 32'hFF);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rd_pulses = 0;
        cyc_n = 0;
        first_rd = -1;
        first_val = -1;
        s_rd_en = 1'b0;
        rst = 1'b0;
        en = 1'b0;
        ifc.empty = 1'b1;
        ifc.rdata = '0;
        ifc.underflow = 1'b0;
        ifc.m_ready = 1'b0;

        //            en    rdy   push cyc pls occ   val   head   cnt
        vecs[0] = '{1'b1, 1'b1, 0, 4, 0, 2'd0, 1'b0, 8'h00, 0};
        vecs[1] = '{1'b1, 1'b1, 1, 4, 1, 2'd0, 1'b0, 8'h00, 1};
        vecs[2] = '{1'b0, 1'b1, 2, 4, 0, 2'd0, 1'b0, 8'h00, 1};
        vecs[3] = '{1'b1, 1'b0, 0, 5, 2, 2'd2, 1'b1, 8'h41, 1};
        vecs[4] = '{1'b1, 1'b0, 3, 4, 0, 2'd2, 1'b1, 8'h41, 1};
        vecs[5] = '{1'b1, 1'b1, 0, 8, 3, 2'd0, 1'b0, 8'h00, 6};
        vecs[6] = '{1'b1, 1'b0, 1, 3, 1, 2'd1, 1'b1, 8'h46, 6};
        vecs[7] = '{1'b0, 1'b1, 0, 3, 0, 2'd0, 1'b0, 8'h00, 7};

        @(negedge clk);
        cyc();
        cyc();

        // Reset values, with a pop opportunity present while rst is low
        en = 1'b1;
        ifc.m_ready = 1'b1;
        push(8'hEE);
        #1;
        check("rst_rd_en", ifc.rd_en, 0);
        check("rst_m_valid", ifc.m_valid, 0);
        check("rst_m_data", ifc.m_data, 0);
        check("rst_occ", occ, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_err_uf", err_uf, 0);
        @(negedge clk);
        fresh();

        // Table-driven run; state carries over from row to row
        next_word = 8'h40;
        for (int r = 0; r < 8; r++) begin
            int p0;
            en = vecs[r].en;
            ifc.m_ready = vecs[r].rdy;
            for (int k = 0; k < vecs[r].n_push; k++) begin
                push(next_word);
                next_word = next_word + 8'd1;
            end
            p0 = rd_pulses;
            for (int c = 0; c < vecs[r].n_cyc; c++) cyc();
            check($sformatf("row%0d_pulses", r), rd_pulses - p0, vecs[r].exp_pulses);
            check($sformatf("row%0d_occ", r), occ, vecs[r].exp_occ);
            check($sformatf("row%0d_valid", r), ifc.m_valid, vecs[r].exp_valid);
            check($sformatf("row%0d_cnt", r), word_cnt, vecs[r].exp_cnt);
            if (vecs[r].exp_valid)
                check($sformatf("row%0d_head", r), ifc.m_data, vecs[r].exp_head);
        end
        check_seq("table_order", 'h40, 1, 7);

        // Three words streamed, pop-to-valid latency
        fresh();
        en = 1'b1;
        ifc.m_ready = 1'b1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        repeat (8) cyc();
        check("stream_pulses", rd_pulses, 3);
        check("stream_latency", first_val - first_rd, 2);
        check_seq("stream_order", 'h11, 'h11, 3);
        check("stream_cnt", word_cnt, 3);

        // Backpressure with six words queued
        fresh();
        en = 1'b1;
        push(8'hA1); push(8'hA2); push(8'hA3);
        push(8'hA4); push(8'hA5); push(8'hA6);
        repeat (4) cyc();
        check("bp_head_early", ifc.m_data, 'hA1);
        repeat (4) cyc();
        check("bp_pulses", rd_pulses, 2);
        check("bp_occ", occ, 2);
        check("bp_valid", ifc.m_valid, 1);
        check("bp_head", ifc.m_data, 'hA1);
        check("bp_fifo_left", fifo_q.size(), 4);
        ifc.m_ready = 1'b1;
        cyc();
        check("bp_rd_en_same_cycle", s_rd_en, 1);
        repeat (5) cyc();
        check_seq("bp_order", 'hA1, 1, 6);
        check("bp_cnt", word_cnt, 6);

        // Empty FIFO for ten cycles
        fresh();
        en = 1'b1;
        ifc.m_ready = 1'b1;
        repeat (10) cyc();
        check("idle_pulses", rd_pulses, 0);
        check("idle_occ", occ, 0);
        check("idle_err_uf", err_uf, 0);

        // Sticky underflow flag
        ifc.underflow = 1'b1;
        cyc();
        ifc.underflow = 1'b0;
        check("uf_set", err_uf, 1);
        repeat (5) cyc();
        check("uf_held", err_uf, 1);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        check("uf_cleared", err_uf, 0);

        // Reset with one word buffered and one in flight
        fresh();
        en = 1'b1;
        push(8'h51);
        push(8'h52);
        push(8'h53);
        cyc();
        cyc();
        check("rstmid_occ_before", occ, 1);
        check("rstmid_pulses_before", rd_pulses, 2);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        check("rstmid_occ", occ, 0);
        check("rstmid_valid", ifc.m_valid, 0);
        check("rstmid_cnt", word_cnt, 0);
        ifc.m_ready = 1'b1;
        repeat (6) cyc();
        check_seq("rstmid_after", 'h53, 1, 1);
        check("rstmid_cnt_after", word_cnt, 1);

        // Enable dropped mid-stream
        fresh();
        en = 1'b1;
        ifc.m_ready = 1'b1;
        push(8'h61); push(8'h62); push(8'h63); push(8'h64); push(8'h65);
        cyc();
        cyc();
        en = 1'b0;
        cyc();
        check("endrop_rd_en", s_rd_en, 0);
        repeat (5) cyc();
        check("endrop_pulses", rd_pulses, 2);
        check("endrop_fifo_left", fifo_q.size(), 3);
        check_seq("endrop_delivered", 'h61, 1, 2);
        en = 1'b1;
        repeat (8) cyc();
        check_seq("endrop_resume", 'h61, 1, 5);
        check("endrop_cnt", word_cnt, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
